fu_result_pager: RTL
====================

FU_RESULT_PAGER -- requirements
Module: fu_result_pager

Interface
REQ-001 Parameter word_Size, default 32, SHALL be the width of the captured function-unit result; it SHALL be a multiple of 8.
REQ-002 Parameter db_Len, default 7, SHALL be the number of consecutive high samples that qualify a button press.
REQ-003 uclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 btn  input  1  SHALL be the raw, unsynchronised page-step push button.
REQ-006 cap_valid  input  1  SHALL request capture of F/V/C/N/Z.
REQ-007 cap_ready  output  1  SHALL indicate that a capture request will be accepted this cycle.
REQ-008 F  input  word_Size  SHALL be the function-unit result word.
REQ-009 V, C, N, Z  input  1 each  SHALL be the overflow, carry, negative and zero flags.
REQ-010 LED  output  8  SHALL be the paged display.
REQ-011 page  output  3  SHALL be the current page index.

Function
REQ-012 The block SHALL implement states EMPTY, LOAD and SHOW.
REQ-013 Capture acceptance SHALL occur on cycles where cap_valid and cap_ready are both 1; cap_ready SHALL be 1 in EMPTY and SHOW and 0 in LOAD.
REQ-014 On acceptance, F and the flags SHALL be registered that cycle, the state SHALL go to LOAD for exactly one cycle, then SHOW with page=0.
REQ-015 In EMPTY and LOAD, LED SHALL be 8'h00.
REQ-016 The page count SHALL be P = word_Size/8 + 1 (5 at default).
REQ-017 In SHOW, pages 0..P-2 SHALL drive LED = captured F byte page (page 0 = F[7:0]).
REQ-018 In SHOW, page P-1 SHALL drive LED = {Z,N,C,V,4'b0000}.
REQ-019 Debounce: btn SHALL be shifted into a db_Len-bit shift register every cycle; the pressed level SHALL be 1 only when all bits are 1.
REQ-020 Step pulse SHALL be pressed AND NOT (pressed registered one cycle earlier), giving one pulse per press.
REQ-021 A step pulse in SHOW SHALL increment page on the next edge; page P-1 SHALL wrap to 0.
REQ-022 Step pulses in EMPTY or LOAD SHALL be ignored; page SHALL remain 0.
REQ-023 Latency: btn high from cycle n SHALL produce the step pulse at cycle n+db_Len, with page updated at edge n+db_Len+1.
REQ-024 On a simultaneous accept and step pulse, the capture SHALL win: the pulse is dropped and page becomes 0.
REQ-025 A new capture accepted in SHOW SHALL overwrite the stored data; LED SHALL read 8'h00 during LOAD, then show page 0 of the new data.
REQ-026 A held button SHALL give no repeated steps; a new step requires pressed to fall and re-qualify.
REQ-027 A btn glitch shorter than db_Len cycles SHALL produce no step.

Reset
REQ-028 rst_n low SHALL immediately force state=EMPTY, page=0, LED=8'h00, cap_ready=1, the debounce register to all-zero, the previous-pressed flag to 0 and the stored result/flags to 0.
REQ-029 Reset asserted mid-LOAD or mid-SHOW SHALL discard the captured data; after release the block SHALL wait in EMPTY for a new capture.

Structure
REQ-030 The state encoding (EMPTY/LOAD/SHOW), page-count constant and flag bit positions SHALL reside in a shared package, fu_pkg.
REQ-031 Debounce plus edge detect SHALL be one sub-module, btn_debounce (parameter db_Len; ports uclk, rst_n, btn, step).

Verification
REQ-032 Reset, then cap_valid=1 with F=32'hA1B2C3D4, V=0, C=1, N=1, Z=0 -> cap_ready=0 for one cycle, LED=8'h00 during LOAD, then LED=8'hD4 with page=0.
REQ-033 Five clean presses after REQ-032 -> LED sequence C3, B2, A1, 60, D4; page sequence 1, 2, 3, 4, 0.
REQ-034 Pulse btn high for 6 cycles, then hold it high for 40 cycles -> exactly one step, issued 7 cycles after the hold begins.
REQ-035 Step pulse coincident with capture of F=32'h0000_00FF -> page=0 and LED=8'hFF after LOAD.
REQ-036 rst_n low while on page 3 -> LED=8'h00 and page=0 asynchronously; presses after release are ignored until a capture is accepted.
REQ-037 Press btn in EMPTY -> page stays 0 and LED stays 8'h00.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared definitions for the result pager: state encoding, page geometry, flag positions.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fu_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHOW  = 2'd2
  } pager_state_t;

  // Width of the page index output.
  localparam int PAGE_W = 3;

  // Bit positions of the flags within the flag page (low nibble reads zero).
  localparam int FLAG_Z_BIT = 7;
  localparam int FLAG_N_BIT = 6;
  localparam int FLAG_C_BIT = 5;
  localparam int FLAG_V_BIT = 4;

  // One page per result byte plus one trailing flag page.
  function automatic int page_count(input int word_size);
    return word_size / 8 + 1;
  endfunction

  localparam int PAGE_CNT_DEFAULT = page_count(32);

endpackage

// File: rtl/fu_result_pager_if.sv
// Capture request bundle: valid/ready handshake plus result word and flags.
// Latency: none (wires only).
// Backpressure: the slave drops cap_ready while it cannot take a capture.
interface fu_result_pager_if #(
  parameter int word_Size = 32
);
  logic                 cap_valid;
  logic                 cap_ready;
  logic [word_Size-1:0] F;
  logic                 V;
  logic                 C;
  logic                 N;
  logic                 Z;

  modport master (output cap_valid, F, V, C, N, Z, input cap_ready);
  modport slave  (input cap_valid, F, V, C, N, Z, output cap_ready);
endinterface

// File: rtl/btn_debounce.sv
// Debounces a raw push button and emits a one-cycle step pulse per qualified press.
// Latency: btn high from cycle n gives step in cycle n+db_Len.
// Backpressure: none; a held button yields a single pulse until it is released.
module btn_debounce #(
  parameter int db_Len = 7
) (
  input  logic uclk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);

  logic [db_Len-1:0] sh_q, sh_d;
  logic              prev_q;
  logic              pressed;

  // Shift the raw sample in; the press qualifies only once every stored sample is high.
  always_comb begin
    sh_d    = db_Len'({sh_q, btn});
    pressed = &sh_q;
    step    = pressed & ~prev_q;
  end

  // History register and previous-pressed flag for rising-edge detection.
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      prev_q <= pressed;
    end
  end

endmodule

// File: rtl/fu_result_pager.sv
// Captures a function-unit result and flags, then pages them byte-by-byte onto 8 LEDs.
// Latency: accept -> one LOAD cycle (LED dark) -> SHOW page 0; button step moves page next edge.
// Backpressure: cap_ready is low only during the single LOAD cycle.
module fu_result_pager
  import fu_pkg::*;
#(
  parameter int word_Size = 32,  // multiple of 8, at most 56 so pages fit the 3-bit index
  parameter int db_Len    = 7
) (
  input  logic                  uclk,
  input  logic                  rst_n,
  input  logic                  btn,
  fu_result_pager_if.slave      cap,
  output logic [7:0]            LED,
  output logic [PAGE_W-1:0]     page
);

  localparam int                P         = page_count(word_Size);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(P - 1);

  pager_state_t         state_q, state_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic [word_Size-1:0] f_q, f_d;
  logic [7:0]           flag_q, flag_d;
  logic                 step;
  logic                 ready;
  logic                 accept;

  btn_debounce #(.db_Len(db_Len)) u_debounce (
    .uclk  (uclk),
    .rst_n (rst_n),
    .btn   (btn),
    .step  (step)
  );

  assign ready         = (state_q != ST_LOAD);
  assign accept        = cap.cap_valid & ready;
  assign cap.cap_ready = ready;
  assign page          = page_q;

  // Next state: a capture always wins over a step pulse and restarts at page 0.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    f_d     = f_q;
    flag_d  = flag_q;
    if (accept) begin
      state_d            = ST_LOAD;
      page_d             = '0;
      f_d                = cap.F;
      flag_d             = '0;
      flag_d[FLAG_Z_BIT] = cap.Z;
      flag_d[FLAG_N_BIT] = cap.N;
      flag_d[FLAG_C_BIT] = cap.C;
      flag_d[FLAG_V_BIT] = cap.V;
    end else begin
      case (state_q)
        ST_LOAD: state_d = ST_SHOW;
        ST_SHOW: begin
          if (step) begin
            page_d = (page_q == LAST_PAGE) ? '0 : page_q + PAGE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State, page and captured data; reset discards any stored result.
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      page_q  <= '0;
      f_q     <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      f_q     <= f_d;
      flag_q  <= flag_d;
    end
  end

  // Display mux: dark unless showing; last page carries the flags.
  always_comb begin
    LED = 8'h00;
    if (state_q == ST_SHOW) begin
      if (page_q == LAST_PAGE) begin
        LED = flag_q;
      end else begin
        LED = 8'(f_q >> {page_q, 3'b000});
      end
    end
  end

endmodule
